// File: rtl/ft245_sync_dev_emu.sv
`default_nettype none
// ============================================================================
// Module      : ft245_sync_dev_emu
// Description : Device-side model of an FT245 synchronous FIFO interface.
//               Drives RXF#/TXE#, accepts RD#/OE#/WR#/SIWU#, and sources the
//               read-data bus from an internal RX FIFO fed by a byte-stream
//               source. Bytes written by the FPGA land in a TX FIFO that is
//               drained by a byte-stream sink.
//               Optional macro FT245_EMU_LOOPBACK_EN routes the TX FIFO head
//               straight into the RX FIFO (source/sink ports go idle).
// Revision    : 1.0 - initial release
// ============================================================================
module ft245_sync_dev_emu #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       io_clk,
  input  logic       rst,
  input  logic [7:0] io_d_i,
  output logic [7:0] io_d_o,
  output logic       io_d_oe,
  output logic       io_rxf_n,
  output logic       io_txe_n,
  input  logic       io_rd_n,
  input  logic       io_wr_n,
  input  logic       io_oe_n,
  input  logic       io_siwua_n,
  input  logic [7:0] src_data,
  input  logic       src_valid,
  output logic       src_ready,
  output logic [7:0] snk_data,
  output logic       snk_valid,
  input  logic       snk_ready,
  output logic       siwu_pulse,
  output logic       proto_err
);

  localparam int                  c_depth   = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   c_full    = (DEPTH_LOG2 + 1)'(c_depth);
  localparam logic [DEPTH_LOG2:0]   c_cnt_one = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] c_ptr_one = DEPTH_LOG2'(1);

  // Storage and pointers for both FIFOs
  logic [7:0]            rx_mem_q [c_depth];
  logic [7:0]            tx_mem_q [c_depth];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [DEPTH_LOG2:0]   rx_count_q, rx_count_d, tx_count_q, tx_count_d;

  // Interface-side registered flags
  logic rxf_n_q, txe_n_q, d_oe_q, proto_err_q, proto_err_d;
  logic siwua_prev_q, siwu_pulse_q;

  // Handshake qualifiers
  logic       w_rx_not_full, w_rx_not_empty, w_tx_not_empty;
  logic       w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
  logic [7:0] w_rx_push_data, w_tx_head;
  logic       w_err_contention, w_err_no_turnaround;

  assign w_rx_not_full  = (rx_count_q != c_full);
  assign w_rx_not_empty = (rx_count_q != '0);
  assign w_tx_not_empty = (tx_count_q != '0);
  assign w_tx_head      = tx_mem_q[tx_rd_ptr_q];

  // FPGA-facing handshakes: reads need the bus already turned around,
  // writes need the bus released on both sides.
  assign w_rx_pop  = ~io_rd_n & ~rxf_n_q & d_oe_q;
  assign w_tx_push = ~io_wr_n & ~txe_n_q & io_oe_n & ~d_oe_q;

  assign w_err_contention    = ~io_wr_n & ~io_oe_n;
  assign w_err_no_turnaround = ~io_rd_n & ~rxf_n_q & ~d_oe_q;

`ifdef FT245_EMU_LOOPBACK_EN
  // TX head is moved into RX whenever there is room; stream ports go idle.
  logic w_unused_stream;
  assign w_unused_stream = ^{src_data, src_valid, snk_ready};
  assign w_rx_push_data  = w_tx_head;
  assign w_rx_push       = w_tx_not_empty & w_rx_not_full;
  assign w_tx_pop        = w_rx_push;
  assign src_ready       = 1'b0;
  assign snk_valid       = 1'b0;
`else
  assign w_rx_push_data  = src_data;
  assign w_rx_push       = src_valid & w_rx_not_full;
  assign w_tx_pop        = w_tx_not_empty & snk_ready;
  assign src_ready       = w_rx_not_full;
  assign snk_valid       = w_tx_not_empty;
`endif

  // Next-state for pointers, counts and the sticky error flag
  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    rx_count_d  = rx_count_q;
    tx_count_d  = tx_count_q;
    proto_err_d = proto_err_q | w_err_contention | w_err_no_turnaround;

    if (w_rx_push) rx_wr_ptr_d = rx_wr_ptr_q + c_ptr_one;
    if (w_rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + c_ptr_one;
    if (w_tx_push) tx_wr_ptr_d = tx_wr_ptr_q + c_ptr_one;
    if (w_tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + c_ptr_one;

    case ({w_rx_push, w_rx_pop})
      2'b10:   rx_count_d = rx_count_q + c_cnt_one;
      2'b01:   rx_count_d = rx_count_q - c_cnt_one;
      default: rx_count_d = rx_count_q;
    endcase

    case ({w_tx_push, w_tx_pop})
      2'b10:   tx_count_d = tx_count_q + c_cnt_one;
      2'b01:   tx_count_d = tx_count_q - c_cnt_one;
      default: tx_count_d = tx_count_q;
    endcase
  end

  // FIFO storage writes; contents need no reset because pointers gate visibility
  always_ff @(posedge io_clk) begin
    if (w_rx_push) rx_mem_q[rx_wr_ptr_q] <= w_rx_push_data;
    if (w_tx_push) tx_mem_q[tx_wr_ptr_q] <= io_d_i;
  end

  // Control state: pointers, counts, interface flags, SIWU edge detect
  always_ff @(posedge io_clk) begin
    if (!rst) begin
      rx_wr_ptr_q  <= '0;
      rx_rd_ptr_q  <= '0;
      tx_wr_ptr_q  <= '0;
      tx_rd_ptr_q  <= '0;
      rx_count_q   <= '0;
      tx_count_q   <= '0;
      rxf_n_q      <= 1'b1;
      txe_n_q      <= 1'b1;
      d_oe_q       <= 1'b0;
      proto_err_q  <= 1'b0;
      siwua_prev_q <= 1'b1;
      siwu_pulse_q <= 1'b0;
    end else begin
      rx_wr_ptr_q  <= rx_wr_ptr_d;
      rx_rd_ptr_q  <= rx_rd_ptr_d;
      tx_wr_ptr_q  <= tx_wr_ptr_d;
      tx_rd_ptr_q  <= tx_rd_ptr_d;
      rx_count_q   <= rx_count_d;
      tx_count_q   <= tx_count_d;
      rxf_n_q      <= (rx_count_d == '0);
      txe_n_q      <= (tx_count_d == c_full);
      d_oe_q       <= ~io_oe_n;
      proto_err_q  <= proto_err_d;
      siwua_prev_q <= io_siwua_n;
      siwu_pulse_q <= siwua_prev_q & ~io_siwua_n;
    end
  end

  // Empty FIFOs present zero rather than stale storage
  assign io_d_o     = w_rx_not_empty ? rx_mem_q[rx_rd_ptr_q] : 8'h00;
  assign snk_data   = w_tx_not_empty ? w_tx_head : 8'h00;
  assign io_d_oe    = d_oe_q;
  assign io_rxf_n   = rxf_n_q;
  assign io_txe_n   = txe_n_q;
  assign proto_err  = proto_err_q;
  assign siwu_pulse = siwu_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_ft245_sync_dev_emu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ft245_sync_dev_emu
// Description : Self-checking bench for ft245_sync_dev_emu. Inputs change on
//               the falling edge; outputs are sampled on the falling edge.
//               Expected bytes travel through scoreboard queues.
//               Define FT245_EMU_LOOPBACK_EN to exercise the loopback build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ft245_sync_dev_emu;

  logic       io_clk = 1'b0;
  logic       rst;
  logic [7:0] io_d_i;
  logic [7:0] io_d_o;
  logic       io_d_oe, io_rxf_n, io_txe_n;
  logic       io_rd_n, io_wr_n, io_oe_n, io_siwua_n;
  logic [7:0] src_data;
  logic       src_valid, src_ready;
  logic [7:0] snk_data;
  logic       snk_valid, snk_ready;
  logic       siwu_pulse, proto_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_sb[$];
  logic [7:0] tx_sb[$];
  logic [7:0] exp_b;

  always #5 io_clk = ~io_clk;

  ft245_sync_dev_emu #(.DEPTH_LOG2(4)) dut (
    .io_clk(io_clk), .rst(rst), .io_d_i(io_d_i), .io_d_o(io_d_o),
    .io_d_oe(io_d_oe), .io_rxf_n(io_rxf_n), .io_txe_n(io_txe_n),
    .io_rd_n(io_rd_n), .io_wr_n(io_wr_n), .io_oe_n(io_oe_n),
    .io_siwua_n(io_siwua_n), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .snk_data(snk_data), .snk_valid(snk_valid),
    .snk_ready(snk_ready), .siwu_pulse(siwu_pulse), .proto_err(proto_err)
  );

  // Hold reset for n falling edges, then release; scoreboards are flushed
  task automatic apply_reset(input int n);
    rst = 1'b0;
    repeat (n) @(negedge io_clk);
    rst = 1'b1;
    rx_sb.delete();
    tx_sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge io_clk);
    checks++; if (io_rxf_n !== 1'b1) begin errors++; $display("FAIL reset_rxf_n: got %b expected 1", io_rxf_n); end
    checks++; if (io_txe_n !== 1'b1) begin errors++; $display("FAIL reset_txe_n: got %b expected 1", io_txe_n); end
    checks++; if (io_d_oe !== 1'b0) begin errors++; $display("FAIL reset_d_oe: got %b expected 0", io_d_oe); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", proto_err); end
    checks++; if (io_d_o !== 8'h00) begin errors++; $display("FAIL reset_d_o: got %h expected 00", io_d_o); end
    checks++; if (snk_valid !== 1'b0) begin errors++; $display("FAIL reset_snk_valid: got %b expected 0", snk_valid); end
    checks++; if (siwu_pulse !== 1'b0) begin errors++; $display("FAIL reset_siwu: got %b expected 0", siwu_pulse); end
`ifndef FT245_EMU_LOOPBACK_EN
    checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL reset_src_ready: got %b expected 1", src_ready); end
`else
    checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL lb_src_ready: got %b expected 0", src_ready); end
`endif
    rst = 1'b1;
    @(negedge io_clk);
    checks++; if (io_txe_n !== 1'b0) begin errors++; $display("FAIL release_txe_n: got %b expected 0", io_txe_n); end
  endtask

  task automatic test_rx_burst();
    for (int i = 0; i < 4; i++) begin
      @(negedge io_clk);
      src_data  = 8'h10 + 8'(i);
      src_valid = 1'b1;
      rx_sb.push_back(src_data);
    end
    @(negedge io_clk);
    src_valid = 1'b0;
    checks++; if (io_rxf_n !== 1'b0) begin errors++; $display("FAIL rx_rxf_n_filled: got %b expected 0", io_rxf_n); end
    io_oe_n = 1'b0;
    @(negedge io_clk);
    checks++; if (io_d_oe !== 1'b1) begin errors++; $display("FAIL rx_d_oe: got %b expected 1", io_d_oe); end
    io_rd_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_b = rx_sb.pop_front();
      checks++; if (io_d_o !== exp_b) begin errors++; $display("FAIL rx_data[%0d]: got %h expected %h", i, io_d_o, exp_b); end
      @(negedge io_clk);
    end
    io_rd_n = 1'b1;
    checks++; if (io_rxf_n !== 1'b1) begin errors++; $display("FAIL rx_rxf_n_drained: got %b expected 1", io_rxf_n); end
    checks++; if (io_d_o !== 8'h00) begin errors++; $display("FAIL rx_d_o_empty: got %h expected 00", io_d_o); end
    io_oe_n = 1'b1;
    repeat (2) @(negedge io_clk);
  endtask

  task automatic test_tx_full();
    snk_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      checks++; if (io_txe_n !== (tx_sb.size() == 16)) begin errors++; $display("FAIL tx_txe_n[%0d]: got %b expected %b", i, io_txe_n, (tx_sb.size() == 16)); end
      io_d_i  = 8'hA0 + 8'(i);
      io_wr_n = 1'b0;
      if (tx_sb.size() < 16) tx_sb.push_back(io_d_i);
      @(negedge io_clk);
    end
    io_wr_n = 1'b1;
    checks++; if (io_txe_n !== 1'b1) begin errors++; $display("FAIL tx_full_txe_n: got %b expected 1", io_txe_n); end
    snk_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_b = tx_sb.pop_front();
      checks++; if (snk_valid !== 1'b1 || snk_data !== exp_b) begin errors++; $display("FAIL tx_snk[%0d]: got v=%b d=%h expected v=1 d=%h", i, snk_valid, snk_data, exp_b); end
      @(negedge io_clk);
    end
    snk_ready = 1'b0;
    checks++; if (snk_valid !== 1'b0) begin errors++; $display("FAIL tx_drained_valid: got %b expected 0", snk_valid); end
    checks++; if (io_txe_n !== 1'b0) begin errors++; $display("FAIL tx_drained_txe_n: got %b expected 0", io_txe_n); end
  endtask

  task automatic test_contention();
    @(negedge io_clk);
    io_oe_n = 1'b0;
    io_wr_n = 1'b0;
    io_d_i  = 8'h5A;
    @(negedge io_clk);
    io_oe_n = 1'b1;
    io_wr_n = 1'b1;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL contention_err: got %b expected 1", proto_err); end
    repeat (3) @(negedge io_clk);
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL contention_sticky: got %b expected 1", proto_err); end
    checks++; if (snk_valid !== 1'b0) begin errors++; $display("FAIL contention_no_push: got %b expected 0", snk_valid); end
    apply_reset(2);
    @(negedge io_clk);
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL contention_cleared: got %b expected 0", proto_err); end
  endtask

  task automatic test_read_rules();
    // Read while empty with turnaround: ignored and no error
    io_oe_n = 1'b0;
    @(negedge io_clk);
    io_rd_n = 1'b0;
    @(negedge io_clk);
    io_rd_n = 1'b1;
    io_oe_n = 1'b1;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL empty_read_err: got %b expected 0", proto_err); end
    @(negedge io_clk);
    src_data  = 8'h42;
    src_valid = 1'b1;
    rx_sb.push_back(8'h42);
    @(negedge io_clk);
    src_valid = 1'b0;
    // Read without turnaround: flagged, byte stays put
    io_rd_n = 1'b1;
    @(negedge io_clk);
    io_rd_n = 1'b0;
    @(negedge io_clk);
    io_rd_n = 1'b1;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL no_turnaround_err: got %b expected 1", proto_err); end
    checks++; if (io_rxf_n !== 1'b0 || io_d_o !== rx_sb[0]) begin errors++; $display("FAIL no_turnaround_kept: got rxf_n=%b d=%h expected rxf_n=0 d=%h", io_rxf_n, io_d_o, rx_sb[0]); end
    // Reset mid-stream discards the buffered byte
    apply_reset(1);
    @(negedge io_clk);
    checks++; if (io_rxf_n !== 1'b1 || io_d_o !== 8'h00) begin errors++; $display("FAIL reset_discard: got rxf_n=%b d=%h expected rxf_n=1 d=00", io_rxf_n, io_d_o); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_err_clear: got %b expected 0", proto_err); end
  endtask

  task automatic test_simultaneous();
    src_data  = 8'h33;
    src_valid = 1'b1;
    rx_sb.push_back(8'h33);
    @(negedge io_clk);
    src_valid = 1'b0;
    io_oe_n   = 1'b0;
    @(negedge io_clk);
    src_data  = 8'h77;
    src_valid = 1'b1;
    io_rd_n   = 1'b0;
    exp_b = rx_sb.pop_front();
    rx_sb.push_back(8'h77);
    checks++; if (io_d_o !== exp_b) begin errors++; $display("FAIL simul_head_before: got %h expected %h", io_d_o, exp_b); end
    @(negedge io_clk);
    src_valid = 1'b0;
    io_rd_n   = 1'b1;
    checks++; if (io_rxf_n !== 1'b0 || io_d_o !== rx_sb[0]) begin errors++; $display("FAIL simul_head_after: got rxf_n=%b d=%h expected rxf_n=0 d=%h", io_rxf_n, io_d_o, rx_sb[0]); end
    io_rd_n = 1'b0;
    void'(rx_sb.pop_front());
    @(negedge io_clk);
    io_rd_n = 1'b1;
    io_oe_n = 1'b1;
    checks++; if (io_rxf_n !== 1'b1) begin errors++; $display("FAIL simul_count_one: got rxf_n=%b expected 1", io_rxf_n); end
    repeat (2) @(negedge io_clk);
  endtask

  task automatic test_siwu();
    io_siwua_n = 1'b0;
    @(negedge io_clk);
    checks++; if (siwu_pulse !== 1'b1) begin errors++; $display("FAIL siwu_pulse_hi: got %b expected 1", siwu_pulse); end
    @(negedge io_clk);
    checks++; if (siwu_pulse !== 1'b0) begin errors++; $display("FAIL siwu_pulse_lo: got %b expected 0", siwu_pulse); end
    io_siwua_n = 1'b1;
    @(negedge io_clk);
    checks++; if (siwu_pulse !== 1'b0 || io_rxf_n !== 1'b1) begin errors++; $display("FAIL siwu_rise: got pulse=%b rxf_n=%b expected 0/1", siwu_pulse, io_rxf_n); end
  endtask

  task automatic test_loopback();
    @(negedge io_clk);
    io_d_i  = 8'h55;
    io_wr_n = 1'b0;
    rx_sb.push_back(8'h55);
    @(negedge io_clk);
    io_d_i  = 8'hAA;
    rx_sb.push_back(8'hAA);
    @(negedge io_clk);
    io_wr_n = 1'b1;
    checks++; if (io_rxf_n !== 1'b0) begin errors++; $display("FAIL lb_rxf_n: got %b expected 0", io_rxf_n); end
    checks++; if (snk_valid !== 1'b0) begin errors++; $display("FAIL lb_snk_valid: got %b expected 0", snk_valid); end
    io_oe_n = 1'b0;
    @(negedge io_clk);
    io_rd_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_b = rx_sb.pop_front();
      checks++; if (io_d_o !== exp_b) begin errors++; $display("FAIL lb_data[%0d]: got %h expected %h", i, io_d_o, exp_b); end
      @(negedge io_clk);
    end
    io_rd_n = 1'b1;
    io_oe_n = 1'b1;
    checks++; if (io_rxf_n !== 1'b1) begin errors++; $display("FAIL lb_drained: got %b expected 1", io_rxf_n); end
    repeat (2) @(negedge io_clk);
  endtask

  initial begin
    rst = 1'b0; io_d_i = 8'h00; io_rd_n = 1'b1; io_wr_n = 1'b1; io_oe_n = 1'b1;
    io_siwua_n = 1'b1; src_data = 8'h00; src_valid = 1'b0; snk_ready = 1'b0;
    test_reset();
`ifdef FT245_EMU_LOOPBACK_EN
    test_loopback();
    test_contention();
    test_siwu();
`else
    test_rx_burst();
    test_tx_full();
    test_contention();
    test_read_rules();
    test_simultaneous();
    test_siwu();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a stimulus task ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
